// File: rtl/temp_pkg.sv
// Shared constants and FSM state type for the temperature averaging writer.
// The RAM model and the testbench import these so address geometry stays in one place.
package temp_pkg;

  localparam int              ADDR_W  = 11;
  localparam logic [ADDR_W-1:0] RAM_TOP = 11'h7FF;
  localparam int              CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    AVG,
    WRITE
  } state_t;

endpackage

// File: rtl/temp_avg_writer_avg4.sv
// Combinational four-byte adder: 10-bit sum (cannot overflow, max 0x3FC)
// and the truncated average, i.e. the sum divided by four with no rounding.
module avg4 (
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] b3,
  output logic [9:0] sum,
  output logic [7:0] avg
);

  logic [3:0][7:0] bytes_in;
  logic [9:0]      ext [4];

  assign bytes_in = {b3, b2, b1, b0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ext
      assign ext[gi] = {2'b00, bytes_in[gi]};
    end
  endgenerate

  assign sum = ext[0] + ext[1] + ext[2] + ext[3];
  assign avg = sum[9:2];

endmodule

// File: rtl/temp_avg_writer.sv
// Detects each newly completed 32-bit temperature word, averages its four bytes
// and writes the result to an external RAM, filling addresses top-down with wrap.
module temp_avg_writer #(
  parameter int                ADDR_W  = temp_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RAM_TOP = temp_pkg::RAM_TOP,
  parameter int                CNT_W   = temp_pkg::CNT_W
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic [31:0]       all_data,
  input  logic              buffer_full,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  words_written
);

  import temp_pkg::*;

  state_t      state_reg;
  state_t      state_next;
  logic        full_q;
  logic        new_word;
  logic [31:0] word_r;
  logic [9:0]  sum_r;
  logic [9:0]  sum_comb;
  // The sub-block's own average output is redundant here: the FSM divides the
  // registered sum instead, so the arithmetic gets a full cycle of its own.
  logic [7:0]  avg_unused;

  avg4 u_avg4 (
    .b0  (word_r[7:0]),
    .b1  (word_r[15:8]),
    .b2  (word_r[23:16]),
    .b3  (word_r[31:24]),
    .sum (sum_comb),
    .avg (avg_unused)
  );

  // A level that stays high yields exactly one event; high right after reset counts.
  assign new_word = buffer_full & ~full_q;
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (new_word) state_next = CAPTURE;
      CAPTURE: state_next = AVG;
      AVG:     state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      full_q        <= 1'b0;
      word_r        <= '0;
      sum_r         <= '0;
      ram_wr_n      <= 1'b1;
      ram_addr      <= RAM_TOP;
      ram_data      <= '0;
      overrun       <= 1'b0;
      words_written <= '0;
    end else begin
      full_q <= buffer_full;

      if (state_reg == IDLE && new_word) begin
        word_r <= all_data;
      end

      if (state_reg == CAPTURE) begin
        sum_r <= sum_comb;
      end

      // Strobe drops on entry to WRITE so it is low for exactly the WRITE cycle.
      if (state_reg == AVG) begin
        ram_data <= 8'(sum_r >> 2);
        ram_wr_n <= 1'b0;
      end

      if (state_reg == WRITE) begin
        ram_wr_n      <= 1'b1;
        ram_addr      <= (ram_addr == '0) ? RAM_TOP : ram_addr - 1'b1;
        words_written <= words_written + 1'b1;
      end

      // Words arriving while busy (including on the WRITE->IDLE edge) are dropped.
      if (new_word && state_reg != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: doc/temp_avg_writer.md
Name: temp_avg_writer

Overview:
- Downstream consumer of the 4-byte packet buffer.
- Detects each newly completed 32-bit temperature word, computes the truncated average of its four bytes, and writes the 8-bit result to an external 2K x 8 RAM.
- RAM addressing is top-down, starting at RAM_TOP and decrementing with wrap.
- Single-clock block in the 50 MHz read domain; sits between the buffer and the RAM.

Parameters:
- ADDR_W, 11, RAM address width.
- RAM_TOP, 11'h7FF, first write address (loaded at reset).
- CNT_W, 16, width of the written-word counter.

Ports:
- clk_50  in  1  system clock, 50 MHz; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- all_data  in  32  packed word from the buffer; byte k = all_data[8k+7:8k].
- buffer_full  in  1  level; high while a complete word is held in all_data.
- ram_wr_n  out  1  active-low RAM write strobe, registered.
- ram_addr  out  ADDR_W  RAM write address, registered.
- ram_data  out  8  RAM write data, registered.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; set when a new word arrives while busy.
- words_written  out  CNT_W  count of completed RAM writes; wraps.

Behaviour:
- Reset (async, reset_n low) sets:
  - ram_wr_n=1, ram_addr=RAM_TOP, ram_data=0, busy=0, overrun=0, words_written=0.
  - state=IDLE, buffer_full history register=0.
- Reset has priority over everything; reset mid-operation abandons the word with no write.
- Edge detect: new_word = buffer_full & ~full_q, where full_q is buffer_full registered each cycle.
  - A level that stays high produces exactly one event.
  - buffer_full high in the first cycle after reset counts as an event.
- FSM (IDLE, CAPTURE, AVG, WRITE):
  - IDLE: on new_word, latch all_data into word_r and go to CAPTURE (cycle 0).
  - CAPTURE: sum_r <= zero-extended sum of the four bytes, 10 bits, no overflow possible (max 0x3FC). Go to AVG.
  - AVG: ram_data <= sum_r[9:2] (truncating divide by 4, no rounding). Go to WRITE.
  - WRITE: ram_wr_n=0 for exactly this one cycle; ram_addr and ram_data stable throughout. On exit:
    - ram_wr_n returns to 1.
    - ram_addr <= ram_addr-1, with 0 wrapping to RAM_TOP.
    - words_written increments.
    - Go to IDLE.
- Latency: event at posedge N → ram_wr_n low during cycle N+3. Back-to-back events are accepted no sooner than 4 cycles apart.
- Overrun: new_word while state≠IDLE:
  - The word is dropped (not queued) and overrun sets.
  - overrun clears only by reset.
  - An event coinciding with the WRITE→IDLE transition is also dropped.
- ram_data holds its last value between writes; ram_addr is never X after reset.
- Byte order has no effect on the result.

Decomposition:
- Shared package temp_pkg:
  - state enum typedef (IDLE, CAPTURE, AVG, WRITE).
  - RAM_TOP and ADDR_W constants, so the RAM model and testbench share them.
- One sub-module, avg4: purely combinational; four 8-bit inputs → 10-bit sum and 8-bit truncated average. The FSM registers its outputs.
- Everything else (edge detect, FSM, address/counter) stays in temp_avg_writer.

Test Plan:
- Reset check: reset_n low mid-run → all outputs at reset values immediately (asynchronously); ram_addr=0x7FF.
- Basic average: all_data=32'h40302010, buffer_full rises → ram_wr_n low exactly at cycle N+3, ram_data=0x28, ram_addr=0x7FF; then ram_addr=0x7FE and words_written=1.
- Truncation and maximum value:
  - 32'h00000003 → ram_data=0x00.
  - 32'hFFFFFFFF → ram_data=0xFF.
  - 32'h01010102 → ram_data=0x01.
- Level hold and overrun:
  - buffer_full held high 10 cycles → exactly one write.
  - Second rising edge 2 cycles after the first → no second write; overrun=1 and stays 1.
- Wrap-around: 2048 words spaced 6 cycles apart → addresses 0x7FF down to 0x000, then the 2049th write goes to 0x7FF; words_written=2049.
- Reset mid-operation: reset_n pulsed low in AVG → no ram_wr_n pulse; next word writes to 0x7FF with words_written=1.
